// File: rtl/uart_transmitter.sv
// Byte-wide UART transmitter: start bit, 8 data bits LSB first, STOP_BITS stop bits,
// paced by the shared tick_in enable, with a one-byte holding register for gapless streaming.
module uart_transmitter #(
  parameter int TICKS_PER_BIT = 16,
  parameter int STOP_BITS     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic [7:0] bus,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       dcom,
  output logic       busy,
  output logic       tx_done
);
  localparam int STOP_TICKS = STOP_BITS * TICKS_PER_BIT;
  localparam int CW         = $clog2(STOP_TICKS + 1);
  localparam logic [CW-1:0] BIT_LIM  = CW'(TICKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LIM = CW'(STOP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic [7:0]    hold;
  logic          hold_full;
  logic          bit_end;
  logic          stop_end;
  logic          load;
  logic          accept;

  // A tick completes a period when the count already sits one below the limit,
  // so the entry edge is never counted and the counter never reaches the limit.
  assign bit_end  = tick_in && (cnt == BIT_LIM);
  assign stop_end = tick_in && (cnt == STOP_LIM);
  assign load     = hold_full && ((state == IDLE) || ((state == STOP) && stop_end));
  assign accept   = byte_valid && byte_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      byte_ready <= 1'b1;
      dcom       <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      // Holding-to-shift transfer takes priority over a new capture.
      if (load) begin
        hold_full  <= 1'b0;
        byte_ready <= 1'b1;
      end else if (accept) begin
        hold       <= bus;
        hold_full  <= 1'b1;
        byte_ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (load) begin
            shift <= hold;
            cnt   <= '0;
            dcom  <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            idx   <= '0;
            dcom  <= shift[0];
            state <= DATA;
          end else if (tick_in) begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == 3'd7) begin
              dcom  <= 1'b1;
              state <= STOP;
            end else begin
              idx  <= idx + 3'd1;
              dcom <= shift[idx + 3'd1];
            end
          end else if (tick_in) begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (stop_end) begin
            cnt     <= '0;
            tx_done <= 1'b1;
            if (hold_full) begin
              shift <= hold;
              dcom  <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else if (tick_in) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          dcom  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: three configurations, per-instance line decoders
// pop expected bytes and check every bit value, bit length and the tx_done pulse.
module tb_uart_transmitter;
  localparam int ND = 3;

  typedef struct {
    logic [7:0] data;
    bit         gap0;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick_in;
  logic [7:0]    bus;
  logic [ND-1:0] valid;
  logic [ND-1:0] ready;
  logic [ND-1:0] dcom;
  logic [ND-1:0] busy;
  logic [ND-1:0] done;

  exp_t sb[ND][$];
  int   checks = 0;
  int   errors = 0;
  int   pulses[ND];
  int   tick_div = 1;

  always #5 clk = ~clk;

  uart_transmitter #(.TICKS_PER_BIT(16), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .bus(bus), .byte_valid(valid[0]),
    .byte_ready(ready[0]), .dcom(dcom[0]), .busy(busy[0]), .tx_done(done[0]));
  uart_transmitter #(.TICKS_PER_BIT(4), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .bus(bus), .byte_valid(valid[1]),
    .byte_ready(ready[1]), .dcom(dcom[1]), .busy(busy[1]), .tx_done(done[1]));
  uart_transmitter #(.TICKS_PER_BIT(16), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .bus(bus), .byte_valid(valid[2]),
    .byte_ready(ready[2]), .dcom(dcom[2]), .busy(busy[2]), .tx_done(done[2]));

  function automatic int tpb(input int d);
    return (d == 1) ? 4 : 16;
  endfunction

  function automatic int stopb(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // Tick enable: one clk-wide pulse every tick_div cycles, driven on the falling edge.
  initial begin
    int c;
    c = 0;
    tick_in = 1'b0;
    forever begin
      @(negedge clk);
      c++;
      if (c >= tick_div) begin
        c = 0;
        tick_in = 1'b1;
      end else begin
        tick_in = 1'b0;
      end
    end
  end

  // Advance to the next clk edge that carries a tick; every non-tick cycle must hold the line.
  task automatic wait_tick(input int d, input logic cur, inout bit stable, inout int cyc,
                           output bit ok);
    bit t;
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk);
      t = tick_in;
      #1;
      cyc++;
      if (rst) return;
      if (t) begin
        ok = 1'b1;
        return;
      end
      if (dcom[d] !== cur || done[d] !== 1'b0 || busy[d] !== 1'b1) stable = 1'b0;
    end
    fail_now($sformatf("tick_wait_dut%0d", d));
  endtask

  task automatic run_frame(input int d, input bit cont);
    exp_t e;
    logic cur;
    int   lim;
    int   cyc;
    bit   stable;
    bit   ok;
    if (sb[d].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame_dut%0d actual=frame expected=none", d);
      e.data = 8'h00;
      e.gap0 = cont;
    end else begin
      e = sb[d].pop_front();
    end
    chk($sformatf("zero_gap_dut%0d_%02h", d, e.data), 32'(cont), 32'(e.gap0));
    for (int b = 0; b < 10; b++) begin
      cur    = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[b-1];
      lim    = (b == 9) ? tpb(d) * stopb(d) : tpb(d);
      stable = (dcom[d] === cur);
      cyc    = 0;
      for (int k = 1; k <= lim; k++) begin
        wait_tick(d, cur, stable, cyc, ok);
        if (!ok) return;
        if (k < lim && (dcom[d] !== cur || done[d] !== 1'b0)) stable = 1'b0;
      end
      chk($sformatf("bit%0d_dut%0d_%02h", b, d, e.data), 32'(stable), 32'd1);
      if (b >= 1) chk($sformatf("bitlen%0d_dut%0d", b, d), 32'(cyc), 32'(lim * tick_div));
    end
    chk($sformatf("tx_done_dut%0d_%02h", d, e.data), 32'(done[d]), 32'd1);
  endtask

  for (genvar g = 0; g < ND; g++) begin : g_mon
    initial begin
      bit cont;
      forever begin
        @(posedge clk);
        #1;
        cont = 1'b0;
        while (!rst && dcom[g] === 1'b0) begin
          run_frame(g, cont);
          cont = 1'b1;
        end
      end
    end
    initial begin
      pulses[g] = 0;
      forever begin
        @(posedge clk);
        #1;
        if (done[g] === 1'b1) pulses[g]++;
      end
    end
  end

  task automatic send(input int d, input logic [7:0] b, input bit gap0, input bit push);
    exp_t e;
    bit   acc;
    acc = 1'b0;
    @(negedge clk);
    bus      = b;
    valid[d] = 1'b1;
    if (push) begin
      e.data = b;
      e.gap0 = gap0;
      sb[d].push_back(e);
    end
    for (int n = 0; n < 2000 && !acc; n++) begin
      @(posedge clk);
      acc = ready[d];
      @(negedge clk);
    end
    valid[d] = 1'b0;
    if (!acc) fail_now($sformatf("send_dut%0d_%02h", d, b));
  endtask

  task automatic wait_idle(input int d);
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 5000 && !idle; n++) begin
      @(negedge clk);
      idle = (sb[d].size() == 0) && (busy[d] === 1'b0);
    end
    if (!idle) fail_now($sformatf("idle_dut%0d", d));
  endtask

  initial begin
    int p0;
    rst   = 1'b1;
    valid = '0;
    bus   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_dcom%0d", d),  32'(dcom[d]),  32'd1);
      chk($sformatf("rst_ready%0d", d), 32'(ready[d]), 32'd1);
      chk($sformatf("rst_busy%0d", d),  32'(busy[d]),  32'd0);
      chk($sformatf("rst_done%0d", d),  32'(done[d]),  32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single byte with handshake latency: accept at edge N, start bit after N+1.
    bus      = 8'hA5;
    valid[0] = 1'b1;
    sb[0].push_back('{data: 8'hA5, gap0: 1'b0});
    @(posedge clk);
    #1;
    chk("accept_ready_low", 32'(ready[0]), 32'd0);
    chk("accept_dcom_idle", 32'(dcom[0]),  32'd1);
    chk("accept_busy_low",  32'(busy[0]),  32'd0);
    @(negedge clk);
    valid[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("start_dcom_low",   32'(dcom[0]),  32'd0);
    chk("start_ready_high", 32'(ready[0]), 32'd1);
    chk("start_busy_high",  32'(busy[0]),  32'd1);
    wait_idle(0);
    chk("single_busy_drop", 32'(busy[0]), 32'd0);

    // Back-to-back: second byte queued while the first is mid-DATA.
    send(0, 8'h00, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    send(0, 8'hFF, 1'b1, 1'b1);
    wait_idle(0);

    // Backpressure: valid held high, bus changes every cycle; only 0x11 and 0x33 go out.
    @(negedge clk);
    bus      = 8'h11;
    valid[0] = 1'b1;
    sb[0].push_back('{data: 8'h11, gap0: 1'b0});
    sb[0].push_back('{data: 8'h33, gap0: 1'b1});
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus = 8'((k + 1) * 17);
    end
    valid[0] = 1'b0;
    wait_idle(0);

    // Sparse ticks: one tick every 5 clk, 4 ticks per bit.
    tick_div = 5;
    send(1, 8'h3C, 1'b0, 1'b1);
    wait_idle(1);
    tick_div = 1;

    // Two stop bits between back-to-back frames.
    send(2, 8'h81, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    send(2, 8'h42, 1'b1, 1'b1);
    wait_idle(2);

    // Reset mid-DATA with a byte waiting in the holding register.
    send(0, 8'h5A, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    send(0, 8'h77, 1'b0, 1'b0);
    repeat (30) @(negedge clk);
    p0 = pulses[0];
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_dcom",  32'(dcom[0]),  32'd1);
    chk("midrst_busy",  32'(busy[0]),  32'd0);
    chk("midrst_ready", 32'(ready[0]), 32'd1);
    chk("midrst_done",  32'(done[0]),  32'd0);
    sb[0].delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("held_byte_lost_pulses", 32'(pulses[0]), 32'(p0));
    chk("held_byte_lost_line",   32'(dcom[0]),   32'd1);

    chk("pulses_dut0", 32'(pulses[0]), 32'd5);
    chk("pulses_dut1", 32'(pulses[1]), 32'd1);
    chk("pulses_dut2", 32'(pulses[2]), 32'd2);
    for (int d = 0; d < ND; d++) chk($sformatf("sb_empty%0d", d), 32'(sb[d].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
